// File: rtl/thermostat_ctrl_pkg.sv
// Shared definitions for the thermostat controller: state encodings, mode
// constants, default temperature width and the state-to-drive decode.
package thermostat_ctrl_pkg;

  localparam int TEMP_W_DEFAULT = 12;

  localparam logic MODE_HEAT = 1'b0;
  localparam logic MODE_COOL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_HEAT  = 2'b01,
    ST_COOL  = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  typedef struct packed {
    logic a;
    logic b;
    logic fault;
  } drive_t;

  // Heat and cool requests come from distinct states, so they can never be
  // asserted together.
  function automatic drive_t drive_of(state_t s);
    drive_t d;
    d = '0;
    case (s)
      ST_HEAT:  d.a     = 1'b1;
      ST_COOL:  d.b     = 1'b1;
      ST_FAULT: d.fault = 1'b1;
      default:  d       = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/thermostat_ctrl_sat.sv
// Saturating up-counter with synchronous clear; at_max flags the ceiling.
// RST_FULL selects whether reset leaves the counter at MAX or at zero.
module sat_counter #(
  parameter int MAX      = 50,
  parameter bit RST_FULL = 1'b0,
  parameter int W        = $clog2(MAX + 1)
) (
  input  logic clock,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic at_max
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] value;

  // Clear has priority over counting; counting stops at MAX.
  always_ff @(posedge clock or posedge rst) begin
    if (rst)
      value <= RST_FULL ? MAX_V : '0;
    else if (clear)
      value <= '0;
    else if (count && (value != MAX_V))
      value <= value + 1'b1;
  end

  assign at_max = (value == MAX_V);

endmodule

// File: rtl/thermostat_ctrl.sv
// Thermostat decision block: hysteresis compare of room temperature against
// target, minimum dwell between request changes, and stale-sensor timeout.
//
// state | meaning
// IDLE  | no request; status follows mode_in
// HEAT  | heat request (A) asserted
// COOL  | cool request (B) asserted
// FAULT | no sample for TIMEOUT cycles; all requests off
module thermostat_ctrl
  import thermostat_ctrl_pkg::*;
#(
  parameter int TEMP_W    = TEMP_W_DEFAULT,
  parameter int THRESH    = 20,
  parameter int MIN_DWELL = 50,
  parameter int TIMEOUT   = 1000
) (
  input  logic              clock,
  input  logic              rst,
  output logic              A,
  output logic              B,
  output logic              status,
  input  logic [TEMP_W-1:0] target,
  input  logic [TEMP_W-1:0] meas,
  input  logic              meas_valid,
  input  logic              mode_in,
  output logic              sensor_fault
);

  localparam int CW = TEMP_W + 1;
  localparam logic [CW-1:0] THRESH_X = CW'(THRESH);

  logic [CW-1:0] target_x;
  logic [CW-1:0] meas_x;
  logic          heat_on;
  logic          heat_off;
  logic          cool_on;
  logic          cool_off;

  state_t state_q;
  state_t state_d;
  drive_t drv_d;
  logic   status_d;
  logic   dwell_clr;
  logic   dwell_ok;
  logic   fault_exit;
  logic   stale;
  logic   timeout;

  // One extra bit so adding the band can never wrap.
  assign target_x = {1'b0, target};
  assign meas_x   = {1'b0, meas};

  assign heat_on  = (target_x >= (meas_x + THRESH_X));
  assign cool_on  = ((target_x + THRESH_X) <= meas_x);
  assign heat_off = (target_x <= meas_x);
  assign cool_off = (target_x >= meas_x);

  sat_counter #(
    .MAX      (MIN_DWELL),
    .RST_FULL (1'b1)
  ) u_dwell (
    .clock  (clock),
    .rst    (rst),
    .clear  (dwell_clr),
    .count  (1'b1),
    .at_max (dwell_ok)
  );

  // Counts edges since the last sample minus the current one, so at_max with
  // no sample this cycle means this edge is the TIMEOUT-th without a sample.
  sat_counter #(
    .MAX      (TIMEOUT - 1),
    .RST_FULL (1'b0)
  ) u_timeout (
    .clock  (clock),
    .rst    (rst),
    .clear  (meas_valid),
    .count  (1'b1),
    .at_max (stale)
  );

  assign timeout = stale && !meas_valid;

  // Next state with priority timeout > mode change > hysteresis.
  always_comb begin
    state_d    = state_q;
    fault_exit = 1'b0;
    if (timeout) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_FAULT: begin
          if (meas_valid) begin
            state_d    = ST_IDLE;
            fault_exit = 1'b1;
          end
        end
        ST_HEAT: begin
          if (mode_in != status)
            state_d = ST_IDLE;
          else if (meas_valid && dwell_ok && heat_off)
            state_d = ST_IDLE;
        end
        ST_COOL: begin
          if (mode_in != status)
            state_d = ST_IDLE;
          else if (meas_valid && dwell_ok && cool_off)
            state_d = ST_IDLE;
        end
        ST_IDLE: begin
          if (meas_valid && dwell_ok) begin
            if ((status == MODE_HEAT) && heat_on)
              state_d = ST_HEAT;
            else if ((status == MODE_COOL) && cool_on)
              state_d = ST_COOL;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output decode, dwell restart on any request change, status load in IDLE.
  always_comb begin
    drv_d     = drive_of(state_d);
    dwell_clr = fault_exit || (drv_d.a != A) || (drv_d.b != B);
    status_d  = (state_q == ST_IDLE) ? mode_in : status;
  end

  // State and registered outputs; reset drops requests immediately.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      A            <= 1'b0;
      B            <= 1'b0;
      sensor_fault <= 1'b0;
      status       <= MODE_HEAT;
    end else begin
      state_q      <= state_d;
      A            <= drv_d.a;
      B            <= drv_d.b;
      sensor_fault <= drv_d.fault;
      status       <= status_d;
    end
  end

endmodule

// File: tb/tb_thermostat_ctrl.sv
// Bench for thermostat_ctrl: vector table, directed corner sequences and a
// randomized run against a time-stamp based reference model.
module tb_thermostat_ctrl;

  localparam int TEMP_W    = 12;
  localparam int THRESH    = 20;
  localparam int MIN_DWELL = 50;
  localparam int TIMEOUT   = 1000;

  logic              clock = 1'b0;
  logic              rst;
  logic              A;
  logic              B;
  logic              status;
  logic              sensor_fault;
  logic [TEMP_W-1:0] target;
  logic [TEMP_W-1:0] meas;
  logic              meas_valid;
  logic              mode_in;

  int checks   = 0;
  int failures = 0;

  thermostat_ctrl #(
    .TEMP_W    (TEMP_W),
    .THRESH    (THRESH),
    .MIN_DWELL (MIN_DWELL),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clock        (clock),
    .rst          (rst),
    .A            (A),
    .B            (B),
    .status       (status),
    .target       (target),
    .meas         (meas),
    .meas_valid   (meas_valid),
    .mode_in      (mode_in),
    .sensor_fault (sensor_fault)
  );

  always #5 clock = ~clock;

  // Reference model: activity plus time stamps of the last sample and the
  // last request change, all in edges counted since reset release.
  localparam int ACT_OFF = 0, ACT_HEATING = 1, ACT_COOLING = 2, ACT_FAULTED = 3;
  int   m_act;
  logic m_status;
  int   now;
  int   last_sample;
  int   last_toggle;

  task automatic model_reset();
    m_act       = ACT_OFF;
    m_status    = 1'b0;
    now         = 0;
    last_sample = 0;
    last_toggle = -1000000;
  endtask

  task automatic model_edge();
    int   t;
    int   m;
    logic was_idle;
    int   prev_act;
    t        = int'(target);
    m        = int'(meas);
    now      = now + 1;
    was_idle = (m_act == ACT_OFF);
    prev_act = m_act;
    if (!meas_valid && (now - last_sample >= TIMEOUT)) begin
      m_act = ACT_FAULTED;
    end else if (m_act == ACT_FAULTED) begin
      if (meas_valid) begin
        m_act       = ACT_OFF;
        last_toggle = now;
      end
    end else if (m_act != ACT_OFF && mode_in != m_status) begin
      m_act = ACT_OFF;
    end else if (meas_valid && (now - last_toggle > MIN_DWELL)) begin
      if (m_act == ACT_OFF) begin
        if (!m_status && t >= m + THRESH) m_act = ACT_HEATING;
        else if (m_status && t + THRESH <= m) m_act = ACT_COOLING;
      end else if (m_act == ACT_HEATING) begin
        if (t <= m) m_act = ACT_OFF;
      end else if (m_act == ACT_COOLING) begin
        if (t >= m) m_act = ACT_OFF;
      end
    end
    if (meas_valid) last_sample = now;
    if ((prev_act == ACT_HEATING) != (m_act == ACT_HEATING) ||
        (prev_act == ACT_COOLING) != (m_act == ACT_COOLING))
      last_toggle = now;
    if (was_idle) m_status = mode_in;
  endtask

  task automatic check_model();
    logic [3:0] got;
    logic [3:0] want;
    got  = {A, B, status, sensor_fault};
    want = {m_act == ACT_HEATING, m_act == ACT_COOLING, m_status, m_act == ACT_FAULTED};
    checks = checks + 1;
    if (got !== want) begin
      failures = failures + 1;
      $display("FAIL model edge=%0d got A,B,status,fault=%b want %b", now, got, want);
    end
  endtask

  task automatic expect_out(input string name, input logic [3:0] want);
    logic [3:0] got;
    got    = {A, B, status, sensor_fault};
    checks = checks + 1;
    if (got !== want) begin
      failures = failures + 1;
      $display("FAIL %s got A,B,status,fault=%b want %b", name, got, want);
    end
  endtask

  // One clock: model advances on the edge, outputs compared at the negedge.
  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_model();
  endtask

  task automatic drive(input logic v, input logic md, input int tg, input int ms);
    meas_valid = v;
    mode_in    = md;
    target     = TEMP_W'(tg);
    meas       = TEMP_W'(ms);
  endtask

  typedef struct {
    logic v;
    logic md;
    int   tg;
    int   ms;
    logic [3:0] exp_out;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int a_changes;
    int last_a_edge;
    logic prev_a;

    // {valid, mode, target, meas} -> expected {A, B, status, fault}
    vecs[0] = '{1'b1, 1'b0, 260, 230, 4'b1000};
    vecs[1] = '{1'b1, 1'b0, 260, 260, 4'b1000};
    vecs[2] = '{1'b0, 1'b0, 260, 260, 4'b1000};
    vecs[3] = '{1'b0, 1'b1, 260, 260, 4'b0000};
    vecs[4] = '{1'b0, 1'b1, 260, 260, 4'b0010};
    vecs[5] = '{1'b1, 1'b1, 180, 300, 4'b0010};

    rst = 1'b1;
    drive(1'b0, 1'b0, 0, 0);
    repeat (3) @(negedge clock);
    expect_out("reset_state", 4'b0000);
    rst = 1'b0;
    model_reset();

    // Heat engage, dwell hold, mode switch to cooling.
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].v, vecs[i].md, vecs[i].tg, vecs[i].ms);
      step();
      expect_out($sformatf("vec%0d", i), vecs[i].exp_out);
    end

    drive(1'b1, 1'b1, 180, 300);
    repeat (55) step();
    expect_out("cool_after_dwell", 4'b0110);
    drive(1'b1, 1'b1, 180, 180);
    repeat (60) step();
    expect_out("cool_release", 4'b0010);

    // Cooling band edges and compare width.
    drive(1'b1, 1'b1, 180, 199);
    repeat (60) step();
    expect_out("cool_in_band", 4'b0010);
    drive(1'b1, 1'b1, 4090, 4095);
    step();
    expect_out("cool_no_wrap", 4'b0010);
    drive(1'b1, 1'b1, 180, 200);
    step();
    expect_out("cool_engage_200", 4'b0110);
    drive(1'b1, 1'b1, 180, 181);
    repeat (60) step();
    expect_out("cool_hold_181", 4'b0110);
    drive(1'b1, 1'b1, 180, 180);
    step();
    expect_out("cool_off_180", 4'b0010);

    // Stale sensor while cooling.
    drive(1'b1, 1'b1, 180, 190);
    repeat (60) step();
    drive(1'b1, 1'b1, 180, 200);
    step();
    expect_out("cool_before_timeout", 4'b0110);
    drive(1'b0, 1'b1, 180, 200);
    repeat (TIMEOUT - 1) step();
    expect_out("timeout_minus_one", 4'b0110);
    step();
    expect_out("timeout_fault", 4'b0011);
    drive(1'b1, 1'b1, 180, 200);
    step();
    expect_out("fault_recover", 4'b0010);
    step();
    expect_out("recover_dwell_hold", 4'b0010);

    // Dwell guard with thresholds crossed every 5 cycles.
    drive(1'b1, 1'b0, 260, 250);
    step();
    a_changes   = 0;
    last_a_edge = -1000000;
    prev_a      = A;
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 1'b0, 260, ((i / 5) % 2) ? 270 : 230);
      step();
      checks = checks + 1;
      if (A && B) begin
        failures = failures + 1;
        $display("FAIL ab_exclusive edge=%0d got A=%0b B=%0b want not both", now, A, B);
      end
      if (A != prev_a) begin
        checks = checks + 1;
        if (now - last_a_edge <= MIN_DWELL) begin
          failures = failures + 1;
          $display("FAIL dwell_spacing got %0d edges want >%0d", now - last_a_edge, MIN_DWELL);
        end
        a_changes   = a_changes + 1;
        last_a_edge = now;
        prev_a      = A;
      end
    end
    checks = checks + 1;
    if (a_changes < 3) begin
      failures = failures + 1;
      $display("FAIL dwell_activity got %0d A changes want >=3", a_changes);
    end

    // Async reset in the middle of HEAT.
    drive(1'b1, 1'b0, 260, 230);
    repeat (60) step();
    expect_out("heat_before_reset", 4'b1000);
    #2 rst = 1'b1;
    #1 expect_out("async_reset_immediate", 4'b0000);
    @(negedge clock);
    expect_out("reset_held", 4'b0000);
    rst = 1'b0;
    model_reset();
    drive(1'b1, 1'b0, 4095, 4090);
    step();
    expect_out("heat_no_wrap", 4'b0000);
    drive(1'b1, 1'b0, 260, 230);
    step();
    expect_out("heat_after_reset", 4'b1000);

    // Randomized run against the model, including a long sample gap.
    mode_in = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 150 == 0) target = TEMP_W'($urandom_range(150, 300));
      if ($urandom_range(0, 199) == 0) mode_in = ~mode_in;
      if (i >= 2000 && i < 3100) meas_valid = 1'b0;
      else meas_valid = ($urandom_range(0, 3) == 0);
      meas = TEMP_W'(int'(target) + int'($urandom_range(0, 80)) - 40);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
